repeater_arbiter: RTL

Round-robin arbiter and sequencer that shares one single-entry repeater buffer between `NREQ` upstream requesters on a TileLink-style channel. It locks the grant for the length of a multi-beat burst and drives the repeater's enqueue and hold/replay sequencing. It presents one registered output beat to the downstream port. It sits between the per-source request queues and the downstream link, in front of the repeater's protocol checker.

---
 rtl/repeater_arb_pkg.sv | 26 ++
 rtl/repeater_arb_rr.sv | 43 ++++
 rtl/repeater_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/repeater_arb_pkg.sv
//------------------------------------------------------------------------------
// repeater_arb_pkg : shared types and helpers for repeater_arbiter
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package repeater_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Index width for a requester count; never returns zero.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Reserved tag value: all-ones of a tw-bit field (tw up to 32).
  function automatic logic [31:0] reserved_tag(input int tw);
    return (tw >= 32) ? 32'hffff_ffff : ((32'd1 << tw) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/repeater_arb_rr.sv
//------------------------------------------------------------------------------
// repeater_arb_rr : combinational round-robin picker (first valid at/after ptr)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module repeater_arb_rr
  import repeater_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_valid[wrap_add(i_ptr, k)]) begin
        w_found = 1'b1;
        o_idx   = wrap_add(i_ptr, k);
      end
    end
    if (w_found) o_grant = NREQ'(1) << o_idx;
  end

endmodule

`default_nettype wire

// File: rtl/repeater_arbiter.sv
//------------------------------------------------------------------------------
// repeater_arbiter : round-robin burst-locking arbiter feeding a one-entry
// repeater with replay. Optional checks: define REPEATER_ARB_ASSERT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module repeater_arbiter
  import repeater_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int TW   = 8,
  parameter int BW   = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ*TW-1:0]       req_tag,
  input  logic [NREQ*BW-1:0]       req_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     out_repeat,
  output logic [DW-1:0]            out_data,
  output logic [TW-1:0]            out_tag,
  output logic [$clog2(NREQ)-1:0]  out_src,
  output logic                     out_last,
  output logic                     full
);

  localparam int IW = $clog2(NREQ);

  arb_state_e    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_owner;
  logic [BW-1:0] r_beats_left;
  logic          r_full;
  logic          r_last;
  logic [DW-1:0] r_data;
  logic [TW-1:0] r_tag;
  logic [IW-1:0] r_src;

  logic [NREQ-1:0] w_rr_grant;
  logic [IW-1:0]   w_rr_idx;
  logic [NREQ-1:0] w_cand;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_idx_inc;
  logic            w_deq;
  logic            w_enq_ok;
  logic            w_accept;
  logic            w_last;
  logic [BW-1:0]   w_len;
  logic [DW-1:0]   w_data;
  logic [TW-1:0]   w_tag;

  repeater_arb_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx)
  );

  // A replay handshake leaves the entry full, so it also blocks enqueue.
  assign w_deq    = r_full & out_ready & ~out_repeat;
  assign w_enq_ok = ~r_full | w_deq;

  always_comb begin
    w_cand = w_rr_grant;
    w_idx  = w_rr_idx;
    if (r_state == ARB_LOCK) begin
      w_cand = NREQ'(1) << r_owner;
      w_idx  = r_owner;
    end
  end

  assign req_ready = w_enq_ok ? (w_cand & req_valid) : '0;
  assign w_accept  = |req_ready;
  assign w_len     = req_len[w_idx*BW +: BW];
  assign w_data    = req_data[w_idx*DW +: DW];
  assign w_tag     = req_tag[w_idx*TW +: TW];
  assign w_idx_inc = (w_idx == IW'(NREQ-1)) ? '0 : w_idx + IW'(1);
  assign w_last    = (r_state == ARB_LOCK) ? (r_beats_left == BW'(1)) : (w_len == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_beats_left <= '0;
    end else if (w_accept) begin
      if (r_state == ARB_IDLE) begin
        if (w_len == '0) begin
          r_rr_ptr <= w_idx_inc;
        end else begin
          r_state      <= ARB_LOCK;
          r_beats_left <= w_len;
          r_owner      <= w_idx;
        end
      end else begin
        r_beats_left <= r_beats_left - BW'(1);
        if (r_beats_left == BW'(1)) begin
          r_state  <= ARB_IDLE;
          r_rr_ptr <= w_idx_inc;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_last <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
      r_src  <= '0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_last <= w_last;
      r_data <= w_data;
      r_tag  <= w_tag;
      r_src  <= w_idx;
    end else if (w_deq) begin
      r_full <= 1'b0;
    end
  end

  assign out_valid = r_full;
  assign full      = r_full;
  assign out_data  = r_data;
  assign out_tag   = r_tag;
  assign out_src   = r_src;
  assign out_last  = r_last;

`ifdef REPEATER_ARB_ASSERT_EN
  localparam logic [TW-1:0] c_RSV_TAG = TW'(reserved_tag(TW));

  logic [BW-1:0] r_first_len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_first_len <= '0;
    else if (w_accept && r_state == ARB_IDLE) r_first_len <= w_len;
  end

  always @(posedge clock) begin
    if (reset_n) begin
      if (w_accept && w_tag == c_RSV_TAG)
        $fatal(1, "repeater_arbiter: accepted reserved tag from requester %0d", w_idx);
      if (out_repeat && !r_full && out_ready)
        $fatal(1, "repeater_arbiter: out_repeat with no held beat");
      if (r_state == ARB_LOCK && req_valid[r_owner] && w_len != r_first_len)
        $fatal(1, "repeater_arbiter: req_len changed within locked burst");
      if ($countones(req_ready) > 1)
        $fatal(1, "repeater_arbiter: multiple req_ready bits high");
    end
  end
`endif

endmodule

`default_nettype wire
